// File: rtl/kv_req_arbiter.sv
// kv_req_arbiter: shares the single KV-store lookup port between two parser
// channels. Round-robin grant, up to MAX_OUTS lookups in flight, and a tag
// FIFO that routes each in-order DB reply back to the port that issued it.
module kv_req_arbiter #(
    parameter int unsigned KEY_SIZE = 96,
    parameter int unsigned FLAG_W   = 4,
    parameter int unsigned MAX_OUTS = 4,
    localparam int unsigned PTR_W   = $clog2(MAX_OUTS),
    localparam int unsigned CNT_W   = $clog2(MAX_OUTS) + 1
) (
    input  logic                clk156,
    input  logic                eth_rst,
    // port 0: suspect lookups
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [KEY_SIZE-1:0] req0_key,
    input  logic [FLAG_W-1:0]   req0_flag,
    // port 1: filter lookups
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [KEY_SIZE-1:0] req1_key,
    input  logic [FLAG_W-1:0]   req1_flag,
    // KV store request side
    output logic [KEY_SIZE-1:0] in_key,
    output logic [FLAG_W-1:0]   in_flag,
    output logic                in_valid,
    // KV store reply side
    input  logic                out_valid,
    input  logic [FLAG_W-1:0]   out_flag,
    // routed replies
    output logic                rsp0_valid,
    output logic [FLAG_W-1:0]   rsp0_flag,
    output logic                rsp1_valid,
    output logic [FLAG_W-1:0]   rsp1_flag,
    // status
    output logic [CNT_W-1:0]    outs_cnt,
    output logic                err_unexp,
    output logic [7:0]          err_cnt
);

    logic                last_grant_q;  // ID of the most recently granted port
    logic [MAX_OUTS-1:0] tag_q;         // one requester ID per in-flight lookup
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    cnt_q;

    logic can_issue;
    logic grant0;
    logic grant1;
    logic push;
    logic pop;
    logic head_id;
    logic unexp;

    // A reply in this cycle does not free a slot until the next cycle.
    assign can_issue = (cnt_q < CNT_W'(MAX_OUTS));
    assign push      = grant0 | grant1;
    assign pop       = out_valid && (cnt_q != '0);
    assign unexp     = out_valid && (cnt_q == '0);
    assign head_id   = tag_q[rd_ptr_q];

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign outs_cnt   = cnt_q;

    // Round-robin arbitration: on a tie, grant the port that did not win last.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (can_issue) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant_q;
                grant1 = ~last_grant_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    // Round-robin pointer; reset to 1 so port 0 wins the first tie.
    always_ff @(posedge clk156 or posedge eth_rst) begin
        if (eth_rst) begin
            last_grant_q <= 1'b1;
        end else if (push) begin
            last_grant_q <= grant1;
        end
    end

    // Tag FIFO: push requester ID on issue, pop head on a matched reply.
    always_ff @(posedge clk156 or posedge eth_rst) begin
        if (eth_rst) begin
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                tag_q[wr_ptr_q] <= grant1;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // Request register towards the KV store; key/flag hold between issues.
    always_ff @(posedge clk156 or posedge eth_rst) begin
        if (eth_rst) begin
            in_valid <= 1'b0;
            in_key   <= '0;
            in_flag  <= '0;
        end else begin
            in_valid <= push;
            if (push) begin
                in_key  <= grant1 ? req1_key : req0_key;
                in_flag <= grant1 ? req1_flag : req0_flag;
            end
        end
    end

    // Reply routing: pulse the owner's valid; the other port's flag holds.
    always_ff @(posedge clk156 or posedge eth_rst) begin
        if (eth_rst) begin
            rsp0_valid <= 1'b0;
            rsp0_flag  <= '0;
            rsp1_valid <= 1'b0;
            rsp1_flag  <= '0;
        end else begin
            rsp0_valid <= pop && !head_id;
            rsp1_valid <= pop && head_id;
            if (pop && !head_id) begin
                rsp0_flag <= out_flag;
            end
            if (pop && head_id) begin
                rsp1_flag <= out_flag;
            end
        end
    end

    // Unexpected-reply pulse and saturating error counter.
    always_ff @(posedge clk156 or posedge eth_rst) begin
        if (eth_rst) begin
            err_unexp <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err_unexp <= unexp;
            if (unexp && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_kv_req_arbiter.sv
// tb_kv_req_arbiter: directed and randomized stimulus compared against a
// queue-based behavioural model of the arbiter.
module tb_kv_req_arbiter;

    localparam int unsigned KEY_SIZE = 96;
    localparam int unsigned FLAG_W   = 4;
    localparam int unsigned MAX_OUTS = 4;
    localparam int unsigned CNT_W    = $clog2(MAX_OUTS) + 1;

    logic                clk156;
    logic                eth_rst;
    logic                req0_valid, req1_valid;
    logic                req0_ready, req1_ready;
    logic [KEY_SIZE-1:0] req0_key, req1_key;
    logic [FLAG_W-1:0]   req0_flag, req1_flag;
    logic [KEY_SIZE-1:0] in_key;
    logic [FLAG_W-1:0]   in_flag;
    logic                in_valid;
    logic                out_valid;
    logic [FLAG_W-1:0]   out_flag;
    logic                rsp0_valid, rsp1_valid;
    logic [FLAG_W-1:0]   rsp0_flag, rsp1_flag;
    logic [CNT_W-1:0]    outs_cnt;
    logic                err_unexp;
    logic [7:0]          err_cnt;

    kv_req_arbiter #(
        .KEY_SIZE (KEY_SIZE),
        .FLAG_W   (FLAG_W),
        .MAX_OUTS (MAX_OUTS)
    ) dut (
        .clk156     (clk156),
        .eth_rst    (eth_rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_key   (req0_key),
        .req0_flag  (req0_flag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_key   (req1_key),
        .req1_flag  (req1_flag),
        .in_key     (in_key),
        .in_flag    (in_flag),
        .in_valid   (in_valid),
        .out_valid  (out_valid),
        .out_flag   (out_flag),
        .rsp0_valid (rsp0_valid),
        .rsp0_flag  (rsp0_flag),
        .rsp1_valid (rsp1_valid),
        .rsp1_flag  (rsp1_flag),
        .outs_cnt   (outs_cnt),
        .err_unexp  (err_unexp),
        .err_cnt    (err_cnt)
    );

    initial clk156 = 1'b0;
    always #5 clk156 = ~clk156;

    int tests_run = 0;
    int tests_failed = 0;

    // Behavioural model: in-flight requester IDs in issue order.
    bit                  m_q[$];
    bit                  m_last;
    int                  m_err;
    logic                e_in_valid;
    logic [KEY_SIZE-1:0] e_in_key;
    logic [FLAG_W-1:0]   e_in_flag;
    logic                e_rsp0_valid, e_rsp1_valid;
    logic [FLAG_W-1:0]   e_rsp0_flag, e_rsp1_flag;
    logic                e_err_unexp;
    int                  grant_log[$];

    task automatic check_val(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_last       = 1'b1;
        m_err        = 0;
        e_in_valid   = 1'b0;
        e_in_key     = '0;
        e_in_flag    = '0;
        e_rsp0_valid = 1'b0;
        e_rsp1_valid = 1'b0;
        e_rsp0_flag  = '0;
        e_rsp1_flag  = '0;
        e_err_unexp  = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        check_val({tag, ".in_valid"}, in_valid, e_in_valid);
        check_val({tag, ".in_key"}, in_key, e_in_key);
        check_val({tag, ".in_flag"}, in_flag, e_in_flag);
        check_val({tag, ".rsp0_valid"}, rsp0_valid, e_rsp0_valid);
        check_val({tag, ".rsp0_flag"}, rsp0_flag, e_rsp0_flag);
        check_val({tag, ".rsp1_valid"}, rsp1_valid, e_rsp1_valid);
        check_val({tag, ".rsp1_flag"}, rsp1_flag, e_rsp1_flag);
        check_val({tag, ".outs_cnt"}, outs_cnt, m_q.size());
        check_val({tag, ".err_unexp"}, err_unexp, e_err_unexp);
        check_val({tag, ".err_cnt"}, err_cnt, m_err);
    endtask

    // One clock cycle: drive inputs, check readies, advance model, check outputs.
    task automatic step(input string tag, input logic v0, input logic v1,
                        input logic ov, input logic [FLAG_W-1:0] of);
        int g;
        req0_valid = v0;
        req1_valid = v1;
        req0_key   = {$urandom, $urandom, $urandom};
        req1_key   = {$urandom, $urandom, $urandom};
        req0_flag  = FLAG_W'($urandom);
        req1_flag  = FLAG_W'($urandom);
        out_valid  = ov;
        out_flag   = of;
        #1;
        g = -1;
        if (m_q.size() < MAX_OUTS) begin
            if (v0 && v1) g = m_last ? 0 : 1;
            else if (v0) g = 0;
            else if (v1) g = 1;
        end
        check_val({tag, ".req0_ready"}, req0_ready, g == 0);
        check_val({tag, ".req1_ready"}, req1_ready, g == 1);
        e_rsp0_valid = 1'b0;
        e_rsp1_valid = 1'b0;
        e_err_unexp  = 1'b0;
        if (ov) begin
            if (m_q.size() > 0) begin
                if (m_q.pop_front()) begin
                    e_rsp1_valid = 1'b1;
                    e_rsp1_flag  = of;
                end else begin
                    e_rsp0_valid = 1'b1;
                    e_rsp0_flag  = of;
                end
            end else begin
                e_err_unexp = 1'b1;
                if (m_err < 255) m_err++;
            end
        end
        e_in_valid = (g >= 0);
        if (g >= 0) begin
            m_q.push_back(g == 1);
            m_last    = (g == 1);
            e_in_key  = (g == 1) ? req1_key : req0_key;
            e_in_flag = (g == 1) ? req1_flag : req0_flag;
            grant_log.push_back(g);
        end
        @(posedge clk156);
        #1;
        check_regs(tag);
    endtask

    task automatic async_reset(input string tag);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_valid  = 1'b0;
        #2;
        eth_rst = 1'b1;
        #1;
        model_reset();
        // Outputs must already be cleared, before any clock edge.
        check_regs(tag);
        check_val({tag, ".req0_ready"}, req0_ready, 1'b0);
        check_val({tag, ".req1_ready"}, req1_ready, 1'b0);
        @(posedge clk156);
        #1;
        eth_rst = 1'b0;
    endtask

    initial begin
        logic [KEY_SIZE-1:0] k;
        eth_rst    = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_key   = '0;
        req1_key   = '0;
        req0_flag  = '0;
        req1_flag  = '0;
        out_valid  = 1'b0;
        out_flag   = '0;
        model_reset();
        repeat (2) @(posedge clk156);
        #1;
        check_regs("reset");
        eth_rst = 1'b0;

        // Single request with a fixed key/flag.
        k = 96'h0A000001_0A000002_3039_0000;
        req0_valid = 1'b1;
        req0_key   = k;
        req0_flag  = 4'b0011;
        #1;
        check_val("single.req0_ready", req0_ready, 1'b1);
        @(posedge clk156);
        #1;
        req0_valid = 1'b0;
        check_val("single.in_valid", in_valid, 1'b1);
        check_val("single.in_key", in_key, k);
        check_val("single.in_flag", in_flag, 4'b0011);
        check_val("single.outs_cnt", outs_cnt, 1);
        m_q.push_back(1'b0);
        m_last     = 1'b0;
        e_in_valid = 1'b1;
        e_in_key   = k;
        e_in_flag  = 4'b0011;
        step("single_rsp", 0, 0, 1, 4'b0100);
        check_val("single.rsp0_flag", rsp0_flag, 4'b0100);
        check_val("single.cnt0", outs_cnt, 0);

        // Round-robin with both ports valid until full.
        async_reset("rst_a");
        grant_log.delete();
        for (int i = 0; i < 6; i++) step("rr", 1, 1, 0, '0);
        check_val("rr.ngrants", grant_log.size(), 4);
        for (int i = 0; i < grant_log.size(); i++) check_val("rr.order", grant_log[i], i % 2);
        check_val("rr.full", outs_cnt, 4);

        // Full: reply at R lowers outs_cnt at R+1, ready may rise then.
        step("full_rsp", 1, 1, 1, 4'h9);
        step("full_reissue", 1, 0, 0, '0);
        for (int i = 0; i < 4; i++) step("drain", 0, 0, 1, FLAG_W'(i));

        // In-order routing: issue 1,0,1 then replies 1,2,3.
        step("io_i1", 0, 1, 0, '0);
        step("io_i0", 1, 0, 0, '0);
        step("io_i1b", 0, 1, 0, '0);
        step("io_r1", 0, 0, 1, 4'd1);
        check_val("io.rsp1_first", rsp1_valid, 1'b1);
        step("io_r2", 0, 0, 1, 4'd2);
        check_val("io.rsp0_second", rsp0_flag, 4'd2);
        step("io_r3", 0, 0, 1, 4'd3);
        check_val("io.rsp1_third", rsp1_flag, 4'd3);

        // Simultaneous push/pop at two in flight, exercising pointer wrap.
        step("pp_a", 1, 0, 0, '0);
        step("pp_b", 0, 1, 0, '0);
        for (int i = 0; i < 20; i++) begin
            logic s;
            s = 1'($urandom);
            step("pushpop", s, !s, 1, FLAG_W'($urandom));
            check_val("pushpop.cnt2", outs_cnt, 2);
        end

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            step("rand", ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 60),
                 ($urandom_range(0, 99) < 45), FLAG_W'($urandom));
        end

        // Reset with three in flight, then a stray reply.
        async_reset("rst_b");
        for (int i = 0; i < 3; i++) step("rst_fill", 1, 1, 0, '0);
        check_val("rst.three", outs_cnt, 3);
        async_reset("rst_c");
        step("rst_stray", 0, 0, 1, 4'h5);
        check_val("rst.err_unexp", err_unexp, 1'b1);
        check_val("rst.err_cnt", err_cnt, 1);

        // Unexpected-reply counter saturation.
        async_reset("rst_d");
        for (int i = 0; i < 300; i++) step("unexp", 0, 0, 1, FLAG_W'($urandom));
        check_val("unexp.sat", err_cnt, 255);
        check_val("unexp.no_rsp", {rsp0_valid, rsp1_valid}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
